gradient_stream_unit: RTL and testbench

- Streaming, tile-based spatial/temporal gradient engine for the Lucas-Kanade optical-flow datapath.
- Accepts one (SIDE+2)-pixel row of the current frame and the co-located row of the next frame per handshake beat.
- Holds a 3-row sliding window and emits one SIDE-wide row of Ix/Iy/It per beat.
- Generalises the combinational whole-window gradient stage to back-to-back tiles with latency-insensitive val/rdy flow control and a parametrised pixel width.

---
 rtl/gradient_pkg.sv | 22 ++
 rtl/gradient_row_calc.sv | 49 ++++
 rtl/gradient_stream_unit.sv | 139 +++++++++++++
 tb/tb_gradient_stream_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gradient_pkg.sv
// Shared types and helpers for the gradient stream unit (optional build macro: GRADIENT_HALF_EN).
package gradient_pkg;

  localparam int unsigned PIX_MAX = 64;

  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Exact difference of two zero-extended pixels; callers keep the low PIX_W+1 bits.
  function automatic logic [PIX_MAX:0] pix_diff(input logic [PIX_MAX-1:0] a,
                                                input logic [PIX_MAX-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic int unsigned pix_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/gradient_row_calc.sv
// Combinational SIDE-wide Ix/Iy/It row from the 3-row window and the incoming row.
// GRADIENT_HALF_EN halves Ix and Iy with an arithmetic shift.
module gradient_row_calc
  import gradient_pkg::*;
#(
  parameter  int SIDE     = 3,
  parameter  int PIX_W    = 32,
  localparam int OUT_W    = PIX_W + 1,
  localparam int ROW_BITS = (SIDE + 2) * PIX_W
) (
  input  logic [ROW_BITS-1:0]   prev,
  input  logic [ROW_BITS-1:0]   mid,
  input  logic [ROW_BITS-1:0]   mid_nxt,
  input  logic [ROW_BITS-1:0]   cur,
  output logic [SIDE*OUT_W-1:0] ix,
  output logic [SIDE*OUT_W-1:0] iy,
  output logic [SIDE*OUT_W-1:0] it
);

  for (genvar j = 0; j < SIDE; j++) begin : g_col
    localparam int C = j + 1;
    logic signed [OUT_W-1:0] ix_raw;
    logic signed [OUT_W-1:0] iy_raw;
    logic signed [OUT_W-1:0] it_raw;

    assign ix_raw = OUT_W'(pix_diff(PIX_MAX'(mid[pix_lsb(C+1, PIX_W) +: PIX_W]),
                                    PIX_MAX'(mid[pix_lsb(C-1, PIX_W) +: PIX_W])));
    assign iy_raw = OUT_W'(pix_diff(PIX_MAX'(cur[pix_lsb(C, PIX_W) +: PIX_W]),
                                    PIX_MAX'(prev[pix_lsb(C, PIX_W) +: PIX_W])));
    assign it_raw = OUT_W'(pix_diff(PIX_MAX'(mid_nxt[pix_lsb(C, PIX_W) +: PIX_W]),
                                    PIX_MAX'(mid[pix_lsb(C, PIX_W) +: PIX_W])));

`ifdef GRADIENT_HALF_EN
    assign ix[pix_lsb(j, OUT_W) +: OUT_W] = ix_raw >>> 1;
    assign iy[pix_lsb(j, OUT_W) +: OUT_W] = iy_raw >>> 1;
`else
    assign ix[pix_lsb(j, OUT_W) +: OUT_W] = ix_raw;
    assign iy[pix_lsb(j, OUT_W) +: OUT_W] = iy_raw;
`endif
    assign it[pix_lsb(j, OUT_W) +: OUT_W] = it_raw;
  end

  // Border columns only feed Ix through mid; elsewhere they are not needed.
  logic unused_edges;
  assign unused_edges = ^{prev[0 +: PIX_W], prev[(SIDE+1)*PIX_W +: PIX_W],
                          mid_nxt[0 +: PIX_W], mid_nxt[(SIDE+1)*PIX_W +: PIX_W],
                          cur[0 +: PIX_W], cur[(SIDE+1)*PIX_W +: PIX_W]};

endmodule

// File: rtl/gradient_stream_unit.sv
// Streaming tile gradient engine: 3-row window, fill/stream FSM, registered output row.
// Build macro GRADIENT_HALF_EN selects halved Ix/Iy (see gradient_row_calc).
module gradient_stream_unit
  import gradient_pkg::*;
#(
  parameter  int SIDE     = 3,
  parameter  int PIX_W    = 32,
  localparam int OUT_W    = PIX_W + 1,
  localparam int ROW_W    = (SIDE > 1) ? $clog2(SIDE) : 1,
  localparam int ROW_BITS = (SIDE + 2) * PIX_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [ROW_BITS-1:0]   in_cur,
  input  logic [ROW_BITS-1:0]   in_nxt,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [SIDE*OUT_W-1:0] out_ix,
  output logic [SIDE*OUT_W-1:0] out_iy,
  output logic [SIDE*OUT_W-1:0] out_it,
  output logic [ROW_W-1:0]      out_row,
  output logic                  out_last
);

  localparam int               CNT_W     = $clog2(SIDE + 2);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(SIDE + 1);
  localparam logic [CNT_W-1:0] FIRST_OUT = CNT_W'(2);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       row_cnt_q, row_cnt_d;
  logic [ROW_BITS-1:0]    prev_q, prev_d, mid_q, mid_d, mid_nxt_q, mid_nxt_d;
  logic                   out_val_q, out_val_d, out_last_q, out_last_d;
  logic [ROW_W-1:0]       out_row_q, out_row_d;
  logic [SIDE*OUT_W-1:0]  out_ix_q, out_ix_d, out_iy_q, out_iy_d, out_it_q, out_it_d;
  logic [SIDE*OUT_W-1:0]  calc_ix, calc_iy, calc_it;
  logic                   accept, emit, tile_end;

  // Handshake: a row moves on a clk edge with val && rdy; a new input row may be
  // taken while the held output drains, and outputs stay frozen while out_val && !out_rdy.
  assign in_rdy = !out_val_q || out_rdy;
  assign accept = in_val && in_rdy;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FILL0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        FILL0:   state_d = FILL1;
        FILL1:   state_d = STREAM;
        STREAM:  if (row_cnt_q == LAST_ROW) state_d = FILL0;
        default: state_d = FILL0;
      endcase
    end
  end

  always_comb begin
    emit     = accept && (state_q == STREAM);
    tile_end = emit && (row_cnt_q == LAST_ROW);
  end

  gradient_row_calc #(.SIDE(SIDE), .PIX_W(PIX_W)) u_row_calc (
    .prev    (prev_q),
    .mid     (mid_q),
    .mid_nxt (mid_nxt_q),
    .cur     (in_cur),
    .ix      (calc_ix),
    .iy      (calc_iy),
    .it      (calc_it)
  );

  always_comb begin
    row_cnt_d  = row_cnt_q;
    prev_d     = prev_q;
    mid_d      = mid_q;
    mid_nxt_d  = mid_nxt_q;
    out_val_d  = out_val_q;
    out_last_d = out_last_q;
    out_row_d  = out_row_q;
    out_ix_d   = out_ix_q;
    out_iy_d   = out_iy_q;
    out_it_d   = out_it_q;
    if (accept) begin
      row_cnt_d = tile_end ? '0 : row_cnt_q + CNT_W'(1);
      prev_d    = mid_q;
      mid_d     = in_cur;
      mid_nxt_d = in_nxt;
    end
    if (emit) begin
      out_val_d  = 1'b1;
      out_last_d = tile_end;
      out_row_d  = ROW_W'(row_cnt_q - FIRST_OUT);
      out_ix_d   = calc_ix;
      out_iy_d   = calc_iy;
      out_it_d   = calc_it;
    end else if (out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_cnt_q  <= '0;
      prev_q     <= '0;
      mid_q      <= '0;
      mid_nxt_q  <= '0;
      out_val_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_row_q  <= '0;
      out_ix_q   <= '0;
      out_iy_q   <= '0;
      out_it_q   <= '0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      prev_q     <= prev_d;
      mid_q      <= mid_d;
      mid_nxt_q  <= mid_nxt_d;
      out_val_q  <= out_val_d;
      out_last_q <= out_last_d;
      out_row_q  <= out_row_d;
      out_ix_q   <= out_ix_d;
      out_iy_q   <= out_iy_d;
      out_it_q   <= out_it_d;
    end
  end

  assign out_val  = out_val_q;
  assign out_last = out_last_q;
  assign out_row  = out_row_q;
  assign out_ix   = out_ix_q;
  assign out_iy   = out_iy_q;
  assign out_it   = out_it_q;

endmodule

// File: tb/tb_gradient_stream_unit.sv
// Bench for gradient_stream_unit: tile-level reference model, expected queues, directed steps.
`timescale 1ns/1ps
module tb_gradient_stream_unit;

  localparam int SIDE  = 3;
  localparam int PIX_W = 32;
  localparam int OUT_W = PIX_W + 1;
  localparam int NR    = SIDE + 2;
  localparam int ROW_W = $clog2(SIDE);
  localparam int VW    = SIDE * OUT_W;
`ifdef GRADIENT_HALF_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              in_val, in_rdy, out_val, out_rdy, out_last;
  logic [NR*PIX_W-1:0] in_cur, in_nxt;
  logic [VW-1:0]     out_ix, out_iy, out_it;
  logic [ROW_W-1:0]  out_row;

  always #5 clk = ~clk;

  gradient_stream_unit #(.SIDE(SIDE), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_cur(in_cur), .in_nxt(in_nxt),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_ix(out_ix), .out_iy(out_iy), .out_it(out_it),
    .out_row(out_row), .out_last(out_last)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  bit last_acc;
  bit rand_rdy;
  bit gap_en;
  logic [PIX_W-1:0] tcur[NR][NR];
  logic [PIX_W-1:0] tnxt[NR][NR];
  logic [VW-1:0]    exp_ix_q[$];
  logic [VW-1:0]    exp_iy_q[$];
  logic [VW-1:0]    exp_it_q[$];
  logic [ROW_W-1:0] exp_row_q[$];
  logic             exp_last_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact signed difference of two pixels, optionally floored half.
  function automatic logic [OUT_W-1:0] mdiff(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b, input bit half);
    longint d;
    d = longint'(a) - longint'(b);
    if (half) d = d >>> 1;
    return OUT_W'(d);
  endfunction

  // Expected output row for centre row r = k-1 of the stored tile.
  task automatic push_expected(input int k);
    int r;
    logic [VW-1:0] eix, eiy, eit;
    r = k - 1;
    for (int j = 0; j < SIDE; j++) begin
      eix[j*OUT_W +: OUT_W] = mdiff(tcur[r][j+2], tcur[r][j], HALF);
      eiy[j*OUT_W +: OUT_W] = mdiff(tcur[r+1][j+1], tcur[r-1][j+1], HALF);
      eit[j*OUT_W +: OUT_W] = mdiff(tnxt[r][j+1], tcur[r][j+1], 1'b0);
    end
    exp_ix_q.push_back(eix);
    exp_iy_q.push_back(eiy);
    exp_it_q.push_back(eit);
    exp_row_q.push_back(ROW_W'(k - 2));
    exp_last_q.push_back(k == NR - 1);
  endtask

  // Output monitor, evaluated at the falling edge.
  task automatic sample();
    last_acc = in_val && in_rdy;
    if (out_val === 1'b1) begin
      checks++;
      assert (exp_ix_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed=1 expected=0");
      end
      if (exp_ix_q.size() != 0) begin
        check("out_ix", out_ix, exp_ix_q[0]);
        check("out_iy", out_iy, exp_iy_q[0]);
        check("out_it", out_it, exp_it_q[0]);
        check("out_row", out_row, exp_row_q[0]);
        check("out_last", out_last, exp_last_q[0]);
        if (out_rdy) begin
          void'(exp_ix_q.pop_front());
          void'(exp_iy_q.pop_front());
          void'(exp_it_q.pop_front());
          void'(exp_row_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_row(input int k);
    for (int c = 0; c < NR; c++) begin
      in_cur[c*PIX_W +: PIX_W] = tcur[k][c];
      in_nxt[c*PIX_W +: PIX_W] = tnxt[k][c];
    end
    in_val = 1'b1;
  endtask

  task automatic send_row(input int k);
    int waited;
    waited = 0;
    load_row(k);
    do begin
      tick();
      waited++;
    end while (!last_acc && waited < 100);
    checks++;
    assert (last_acc) else begin
      errors++;
      $error("FAIL accept_timeout row=%0d observed=0 expected=1", k);
    end
    in_val = 1'b0;
    if (k >= 2) push_expected(k);
    if (gap_en) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_tile();
    for (int k = 0; k < NR; k++) send_row(k);
  endtask

  task automatic fill_tile(input int mode);
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NR; c++) begin
        case (mode)
          0: begin tcur[r][c] = PIX_W'(10*r + c);          tnxt[r][c] = tcur[r][c] + 5; end
          1: begin tcur[r][c] = PIX_W'(100 - 7*c - 3*r);   tnxt[r][c] = tcur[r][c] - 9; end
          2: begin
            tcur[r][c] = (((c >> 1) + (r >> 1)) % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
            tnxt[r][c] = 32'h0;
          end
          default: begin tcur[r][c] = $urandom(); tnxt[r][c] = $urandom(); end
        endcase
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 1'b0;
    out_rdy  = 1'b1;
    while (exp_ix_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    assert (exp_ix_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d pending expected=0", exp_ix_q.size());
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; in_val = 1'b0; out_rdy = 1'b1; in_cur = '0; in_nxt = '0;
    rand_rdy = 1'b0; gap_en = 1'b0;
    repeat (3) tick();
    check("rst_out_val", out_val, 1'b0);
    check("rst_out_ix", out_ix, '0);
    check("rst_out_iy", out_iy, '0);
    check("rst_out_it", out_it, '0);
    check("rst_out_row", out_row, '0);
    check("rst_out_last", out_last, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_in_rdy", in_rdy, 1'b1);

    // Ramp tile, back to back, with latency checks on the first output.
    fill_tile(0);
    send_row(0); check("lat_row0_out_val", out_val, 1'b0);
    send_row(1); check("lat_row1_out_val", out_val, 1'b0);
    send_row(2); check("lat_row2_out_val", out_val, 1'b1);
    send_row(3);
    send_row(4);
    drain();

    fill_tile(1); send_tile(); drain();   // negative gradients
    fill_tile(2); send_tile(); drain();   // full-scale extremes

    // Backpressure: hold the first output for 4 cycles with row 3 offered.
    fill_tile(3);
    send_row(0); send_row(1); send_row(2);
    out_rdy = 1'b0;
    load_row(3);
    repeat (4) begin
      tick();
      check("stall_in_rdy", in_rdy, 1'b0);
      check("stall_no_accept", last_acc, 1'b0);
    end
    out_rdy = 1'b1;
    send_row(3);
    send_row(4);
    drain();

    // Two random tiles with input gaps and random output backpressure.
    gap_en = 1'b1; rand_rdy = 1'b1;
    fill_tile(3); send_tile();
    fill_tile(3); send_tile();
    drain();
    gap_en = 1'b0;

    // Reset while the second output row of a tile is presented.
    fill_tile(3);
    send_row(0); send_row(1); send_row(2); send_row(3);
    reset = 1'b0;
    tick();
    check("midrst_out_val", out_val, 1'b0);
    check("midrst_out_ix", out_ix, '0);
    check("midrst_out_row", out_row, '0);
    check("midrst_out_last", out_last, 1'b0);
    exp_ix_q.delete(); exp_iy_q.delete(); exp_it_q.delete();
    exp_row_q.delete(); exp_last_q.delete();
    reset = 1'b1;
    tick();
    check("midrst_in_rdy", in_rdy, 1'b1);
    fill_tile(3); send_tile(); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
